// File: rtl/store_unit.sv
// Store buffer: formats byte/half/word stores into lane-aligned entries, queues
// them in a circular FIFO and drains them to memory or to the LED register.
module store_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALEN      = 32,
  parameter int unsigned LED_WIDTH = 4,
  parameter int unsigned SB_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [ALEN-1:0]      st_addr,
  input  logic [XLEN-1:0]      st_data,
  input  logic [2:0]           st_funct3,
  output logic                 st_error,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic [ALEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [3:0]           mem_wstrb,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 sb_empty
);

  localparam int unsigned PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ALEN-1:0] MMIO_LED_ADDR = ALEN'(32'hFFFF_FFF0);

  typedef enum logic [0:0] {IDLE, REQ} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  logic [ALEN-1:0]      sb_addr  [SB_DEPTH];
  logic [XLEN-1:0]      sb_wdata [SB_DEPTH];
  logic [3:0]           sb_strb  [SB_DEPTH];
  logic                 sb_mmio  [SB_DEPTH];

  logic                 accept_c;
  logic                 bad_c;
  logic                 enq_c;
  logic                 deq_c;
  logic                 mmio_c;
  logic                 head_mmio_c;
  logic [3:0]           strb_c;
  logic [XLEN-1:0]      wdata_c;
  logic [CNT_W-1:0]     count_nxt_c;

  // Store formatting: lane strobes, replicated data and alignment check
  always_comb begin
    strb_c  = 4'b0000;
    wdata_c = '0;
    bad_c   = 1'b0;
    case (st_funct3)
      3'b000: begin
        strb_c  = 4'b0001 << st_addr[1:0];
        wdata_c = XLEN'({4{st_data[7:0]}});
      end
      3'b001: begin
        bad_c   = st_addr[0];
        strb_c  = st_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = XLEN'({2{st_data[15:0]}});
      end
      3'b010: begin
        bad_c   = |st_addr[1:0];
        strb_c  = 4'b1111;
        wdata_c = st_data;
      end
      default: bad_c = 1'b1;
    endcase
  end

  always_comb begin
    accept_c    = st_valid && st_ready;
    enq_c       = accept_c && !bad_c;
    mmio_c      = (st_addr[ALEN-1:2] == MMIO_LED_ADDR[ALEN-1:2]);
    head_mmio_c = sb_mmio[rd_ptr];
    deq_c       = ((state == IDLE) && (count != '0) && head_mmio_c) ||
                  ((state == REQ) && mem_ack);
    count_nxt_c = count + CNT_W'(enq_c) - CNT_W'(deq_c);
  end

  // Entry storage; contents are only meaningful while counted
  always_ff @(posedge clk) begin
    if (enq_c) begin
      sb_addr[wr_ptr]  <= {st_addr[ALEN-1:2], 2'b00};
      sb_wdata[wr_ptr] <= wdata_c;
      sb_strb[wr_ptr]  <= strb_c;
      sb_mmio[wr_ptr]  <= mmio_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      st_error  <= 1'b0;
      led_out   <= '0;
      st_ready  <= 1'b1;
      sb_empty  <= 1'b1;
    end else begin
      st_error <= accept_c && bad_c;
      if (enq_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_nxt_c;
      st_ready <= (count_nxt_c < CNT_W'(SB_DEPTH));
      // A pending or in-flight entry is always still counted, so count alone decides
      sb_empty <= (count_nxt_c == '0);

      case (state)
        IDLE: begin
          if (count != '0) begin
            if (head_mmio_c) begin
              if (sb_strb[rd_ptr][0]) led_out <= sb_wdata[rd_ptr][LED_WIDTH-1:0];
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_addr  <= sb_addr[rd_ptr];
              mem_wdata <= sb_wdata[rd_ptr];
              mem_wstrb <= sb_strb[rd_ptr];
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wstrb <= 4'b0000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: formatting, errors, MMIO, ordering, backpressure, reset.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_error;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [3:0]  led_out;
  logic        sb_empty;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  store_unit dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3), .st_error(st_error),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .led_out(led_out), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Record completed memory writes and every cycle with mem_req high
  always @(posedge clk) begin
    if (mem_req) req_cycles++;
    if (mem_req && mem_ack) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int n = 0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f;
    while (!st_ready && n < 20) begin tick(); n++; end
    if (!st_ready) check("store_timeout", 32'(st_ready), 1);
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin tick(); n++; end
    check(tag, 32'(mem_req), 1);
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!sb_empty && n < 40) begin tick(); n++; end
    check(tag, 32'(sb_empty), 1);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 32'(st_ready), 1);
    check("rst_empty", 32'(sb_empty), 1);
    check("rst_req", 32'(mem_req), 0);
    check("rst_strb", 32'(mem_wstrb), 0);
    check("rst_err", 32'(st_error), 0);
    check("rst_led", 32'(led_out), 0);

    // Byte store, latency to mem_req and hold until ack
    do_store(32'h0000_1003, 32'h0000_00AB, 3'b000);
    check("sb_n1_req", 32'(mem_req), 0);
    check("sb_n1_empty", 32'(sb_empty), 0);
    check("sb_n1_strb", 32'(mem_wstrb), 0);
    tick();
    check("sb_n2_req", 32'(mem_req), 1);
    check("sb_addr", mem_addr, 32'h0000_1000);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_wstrb", 32'(mem_wstrb), 32'h8);
    tick();
    check("sb_hold_req", 32'(mem_req), 1);
    check("sb_hold_addr", mem_addr, 32'h0000_1000);
    ack();
    check("sb_ack_req", 32'(mem_req), 0);
    check("sb_ack_strb", 32'(mem_wstrb), 0);
    check("sb_ack_empty", 32'(sb_empty), 1);

    // Half stores: aligned upper half, then misaligned and illegal funct3
    do_store(32'h0000_2002, 32'h0000_1234, 3'b001);
    wait_req("sh_req");
    check("sh_addr", mem_addr, 32'h0000_2000);
    check("sh_wdata", mem_wdata, 32'h1234_1234);
    check("sh_wstrb", 32'(mem_wstrb), 32'hC);
    ack();
    tick();
    req_cycles = 0;
    do_store(32'h0000_2001, 32'h0000_1234, 3'b001);
    check("sh_mis_err", 32'(st_error), 1);
    check("sh_mis_empty", 32'(sb_empty), 1);
    tick();
    check("sh_mis_err_off", 32'(st_error), 0);
    check("sh_mis_empty2", 32'(sb_empty), 1);
    do_store(32'h0000_3000, 32'h0000_0055, 3'b011);
    check("f3_bad_err", 32'(st_error), 1);
    tick(); tick();
    check("bad_no_req", 32'(req_cycles), 0);

    // MMIO LED: word write updates, byte at lane 1 does not
    do_store(32'hFFFF_FFF0, 32'h0000_0005, 3'b010);
    tick();
    check("mmio_led", 32'(led_out), 5);
    check("mmio_empty", 32'(sb_empty), 1);
    do_store(32'hFFFF_FFF1, 32'h0000_000F, 3'b000);
    tick(); tick();
    check("mmio_led_keep", 32'(led_out), 5);
    check("mmio_no_req", 32'(req_cycles), 0);

    // Three back-to-back words with backpressure, in-order drain
    wq_addr.delete(); wq_data.delete();
    do_store(32'h0000_0100, 32'hAAAA_0001, 3'b010);
    do_store(32'h0000_0104, 32'hBBBB_0002, 3'b010);
    check("full_ready", 32'(st_ready), 0);
    check("full_req", 32'(mem_req), 1);
    mem_ack = 1'b1;
    do_store(32'h0000_0108, 32'hCCCC_0003, 3'b010);
    wait_empty("order_drain");
    mem_ack = 1'b0;
    check("order_n", 32'(wq_addr.size()), 3);
    if (wq_addr.size() == 3) begin
      check("order_a", wq_addr[0], 32'h0000_0100);
      check("order_b", wq_addr[1], 32'h0000_0104);
      check("order_c", wq_addr[2], 32'h0000_0108);
      check("order_cd", wq_data[2], 32'hCCCC_0003);
    end

    // Enqueue and dequeue in the same cycle leave count unchanged
    wq_addr.delete(); wq_data.delete();
    do_store(32'h0000_0200, 32'h1111_1111, 3'b010);
    wait_req("ed_req");
    check("ed_ready0", 32'(st_ready), 1);
    st_valid = 1'b1; st_addr = 32'h0000_0204; st_data = 32'h2222_2222; st_funct3 = 3'b010;
    mem_ack = 1'b1;
    tick();
    st_valid = 1'b0; mem_ack = 1'b0;
    check("ed_ready", 32'(st_ready), 1);
    check("ed_empty", 32'(sb_empty), 0);
    check("ed_req_low", 32'(mem_req), 0);
    wait_req("ed_req2");
    check("ed_addr2", mem_addr, 32'h0000_0204);
    ack();
    tick();
    check("ed_n", 32'(wq_addr.size()), 2);
    check("ed_done", 32'(sb_empty), 1);

    // Reset during an in-flight request with an MMIO store queued behind it
    do_store(32'h0000_0300, 32'h3333_3333, 3'b010);
    do_store(32'hFFFF_FFF0, 32'h0000_000A, 3'b010);
    wait_req("rst_mid_req");
    check("rst_mid_full", 32'(st_ready), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_req0", 32'(mem_req), 0);
    check("rst_mid_empty", 32'(sb_empty), 1);
    check("rst_mid_led", 32'(led_out), 0);
    check("rst_mid_ready", 32'(st_ready), 1);
    check("rst_mid_strb", 32'(mem_wstrb), 0);
    tick(); tick(); tick();
    check("rst_after_led", 32'(led_out), 0);
    check("rst_after_req", 32'(mem_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
